sal_cmd_sched: RTL

Channel-level DRAM command scheduler that sits between the per-bank controllers and the DFI control interface. Each cycle it picks at most one command (REF/PRE/RD/WR/ACT) from the bank controllers and grants it. It enforces the inter-bank timing constraints that no single bank can see: tRRD, tCCD, write-to-read and read-to-write turnaround. It drives the shared DFI command bus with a registered command, or NOP when idle.

---
 rtl/sal_sched_pkg.sv | 22 ++
 rtl/sal_rr_arb.sv | 34 +++
 rtl/sal_cmd_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sal_sched_pkg.sv
// sal_sched_pkg: shared command types and DFI encodings
// for the channel command scheduler.
package sal_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] DFI_NOP = 4'b1111;
  localparam logic [3:0] DFI_ACT = 4'b0011;
  localparam logic [3:0] DFI_RD  = 4'b0101;
  localparam logic [3:0] DFI_WR  = 4'b0100;
  localparam logic [3:0] DFI_PRE = 4'b0010;
  localparam logic [3:0] DFI_REF = 4'b0001;

endpackage

// File: rtl/sal_rr_arb.sv
// sal_rr_arb: round-robin pick of one requester,
// searching upward from ptr_i with wrap.
module sal_rr_arb
  import sal_sched_pkg::*;
#(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o
);

  logic         hit;
  logic [W-1:0] k;

  // First requester at or after the pointer wins
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = ptr_i + W'(i);
      if (!hit && req_i[k]) begin
        hit      = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/sal_cmd_sched.sv
// sal_cmd_sched: picks one bank command per cycle, enforces
// inter-bank timing and drives a registered DFI command.
module sal_cmd_sched
  import sal_sched_pkg::*;
#(
  parameter int NUM_BK     = 4,
  parameter int BA_WIDTH   = 2,
  parameter int ADDR_WIDTH = 14,
  parameter int T_WIDTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_BK-1:0]            cmd_valid_i,
  input  logic [NUM_BK*3-1:0]          cmd_type_i,
  input  logic [NUM_BK*ADDR_WIDTH-1:0] cmd_addr_i,
  output logic [NUM_BK-1:0]            cmd_gnt_o,
  input  logic [T_WIDTH-1:0]           t_rrd_i,
  input  logic [T_WIDTH-1:0]           t_ccd_i,
  input  logic [T_WIDTH-1:0]           t_wtr_i,
  input  logic [T_WIDTH-1:0]           t_rtw_i,
  output logic                         dfi_cke_o,
  output logic                         dfi_cs_n_o,
  output logic                         dfi_ras_n_o,
  output logic                         dfi_cas_n_o,
  output logic                         dfi_we_n_o,
  output logic [BA_WIDTH-1:0]          dfi_ba_o,
  output logic [ADDR_WIDTH-1:0]        dfi_addr_o
);

  typedef logic [T_WIDTH-1:0] tcnt_t;

  function automatic tcnt_t ld(input tcnt_t t);
    return (t == '0) ? '0 : t - T_WIDTH'(1);
  endfunction

  function automatic tcnt_t dec(input tcnt_t c);
    return (c == '0) ? '0 : c - T_WIDTH'(1);
  endfunction

  tcnt_t rrd_q, rrd_d, ccd_q, ccd_d;
  tcnt_t wtr_q, wtr_d, rtw_q, rtw_d;

  logic [BA_WIDTH-1:0]   rr_q, rr_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [BA_WIDTH-1:0]   ba_q, ba_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cke_q;

  logic [2:0]            typ [NUM_BK];
  logic [ADDR_WIDTH-1:0] adr [NUM_BK];

  logic [NUM_BK-1:0] ref_req, pre_req, col_req, act_req;
  logic [NUM_BK-1:0] ref_gnt, pre_gnt, col_gnt, act_gnt;
  logic [BA_WIDTH-1:0] ref_idx, pre_idx, col_idx, act_idx;

  logic [NUM_BK-1:0]     sel_gnt;
  logic [BA_WIDTH-1:0]   gidx;
  logic                  any;
  logic [2:0]            gtype;
  logic [ADDR_WIDTH-1:0] gaddr;

  for (genvar b = 0; b < NUM_BK; b++) begin : g_bk
    assign typ[b] = cmd_type_i[b*3 +: 3];
    assign adr[b] = cmd_addr_i[b*ADDR_WIDTH +: ADDR_WIDTH];
    assign ref_req[b] = cmd_valid_i[b] && (typ[b] == CMD_REF);
    assign pre_req[b] = cmd_valid_i[b] && (typ[b] == CMD_PRE);
    assign act_req[b] = cmd_valid_i[b] && (typ[b] == CMD_ACT)
                      && (rrd_q == '0);
    assign col_req[b] = cmd_valid_i[b] && (ccd_q == '0) &&
                        (((typ[b] == CMD_RD) && (wtr_q == '0)) ||
                         ((typ[b] == CMD_WR) && (rtw_q == '0)));
  end

  sal_rr_arb #(.N(NUM_BK), .W(BA_WIDTH)) u_arb_ref (
    .req_i(ref_req), .ptr_i(rr_q), .gnt_o(ref_gnt), .idx_o(ref_idx)
  );
  sal_rr_arb #(.N(NUM_BK), .W(BA_WIDTH)) u_arb_pre (
    .req_i(pre_req), .ptr_i(rr_q), .gnt_o(pre_gnt), .idx_o(pre_idx)
  );
  sal_rr_arb #(.N(NUM_BK), .W(BA_WIDTH)) u_arb_col (
    .req_i(col_req), .ptr_i(rr_q), .gnt_o(col_gnt), .idx_o(col_idx)
  );
  sal_rr_arb #(.N(NUM_BK), .W(BA_WIDTH)) u_arb_act (
    .req_i(act_req), .ptr_i(rr_q), .gnt_o(act_gnt), .idx_o(act_idx)
  );

  // Serve only the highest non-empty eligible class
  always_comb begin
    sel_gnt = '0;
    gidx    = '0;
    if (rst_n) begin
      if (|ref_req) begin
        sel_gnt = ref_gnt;
        gidx    = ref_idx;
      end else if (|pre_req) begin
        sel_gnt = pre_gnt;
        gidx    = pre_idx;
      end else if (|col_req) begin
        sel_gnt = col_gnt;
        gidx    = col_idx;
      end else if (|act_req) begin
        sel_gnt = act_gnt;
        gidx    = act_idx;
      end
    end
  end

  assign cmd_gnt_o = sel_gnt;
  assign any       = |sel_gnt;
  assign gtype     = typ[gidx];
  assign gaddr     = adr[gidx];

  // Counter loads win over the per-cycle decrement
  always_comb begin
    rrd_d = dec(rrd_q);
    ccd_d = dec(ccd_q);
    wtr_d = dec(wtr_q);
    rtw_d = dec(rtw_q);
    rr_d  = rr_q;
    if (any) begin
      rr_d = gidx + BA_WIDTH'(1);
      if (gtype == CMD_ACT) rrd_d = ld(t_rrd_i);
      if (gtype == CMD_RD || gtype == CMD_WR) ccd_d = ld(t_ccd_i);
      if (gtype == CMD_WR) wtr_d = ld(t_wtr_i);
      if (gtype == CMD_RD) rtw_d = ld(t_rtw_i);
    end
  end

  // Encode the granted command for the DFI bus
  always_comb begin
    cmd_d  = DFI_NOP;
    ba_d   = '0;
    addr_d = '0;
    if (any) begin
      ba_d   = gidx;
      addr_d = gaddr;
      case (gtype)
        CMD_ACT: cmd_d = DFI_ACT;
        CMD_RD:  cmd_d = DFI_RD;
        CMD_WR:  cmd_d = DFI_WR;
        CMD_PRE: cmd_d = DFI_PRE;
        CMD_REF: cmd_d = DFI_REF;
        default: cmd_d = DFI_NOP;
      endcase
    end
  end

  // State and DFI output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrd_q  <= '0;
      ccd_q  <= '0;
      wtr_q  <= '0;
      rtw_q  <= '0;
      rr_q   <= '0;
      cmd_q  <= DFI_NOP;
      ba_q   <= '0;
      addr_q <= '0;
      cke_q  <= 1'b1;
    end else begin
      rrd_q  <= rrd_d;
      ccd_q  <= ccd_d;
      wtr_q  <= wtr_d;
      rtw_q  <= rtw_d;
      rr_q   <= rr_d;
      cmd_q  <= cmd_d;
      ba_q   <= ba_d;
      addr_q <= addr_d;
      cke_q  <= 1'b1;
    end
  end

  assign dfi_cke_o = cke_q;
  assign {dfi_cs_n_o, dfi_ras_n_o, dfi_cas_n_o, dfi_we_n_o} = cmd_q;
  assign dfi_ba_o   = ba_q;
  assign dfi_addr_o = addr_q;

endmodule
